// File: rtl/noc_packetizer.sv
// rtl/noc_packetizer.sv - NoC injection interface: buffers payload beats, emits header flit then payload
// Messages longer than MAX_PAYLOAD beats leave as several packets; the continuation bit marks all but the last.
module noc_packetizer #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int ROUTER_X      = 0,
  parameter int ROUTER_Y      = 0,
  parameter int MAX_PAYLOAD   = 4,
  localparam int XW = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1,
  localparam int YW = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  input  logic                  s_tlast_i,
  output logic                  s_tready_o,
  input  logic [XW-1:0]         dest_x_i,
  input  logic [YW-1:0]         dest_y_i,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  output logic                  m_tlast_o,
  input  logic                  m_tready_i
);
  localparam int LW    = $clog2(MAX_PAYLOAD + 1);
  localparam int IW    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [1:0] {COLLECT, HEADER, PAYLOAD} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buffer_q [DEPTH];
  logic [LW-1:0]         cnt_q, rd_q, len_q, cnt_inc;
  logic [XW-1:0]         dest_x_q;
  logic [YW-1:0]         dest_y_q;
  logic                  cont_q, first_q, s_tready_q, m_tvalid_q;
  logic                  s_hs, m_hs, close_beat, last_flit;
  logic [DATA_WIDTH-1:0] header;

  assign s_hs       = s_tvalid_i & s_tready_q;
  assign m_hs       = m_tvalid_q & m_tready_i;
  assign cnt_inc    = cnt_q + LW'(1);
  assign close_beat = s_tlast_i || (cnt_inc == LW'(MAX_PAYLOAD));
  assign last_flit  = (rd_q == len_q - LW'(1));
  assign s_tready_o = s_tready_q;
  assign m_tvalid_o = m_tvalid_q;

  always_comb begin
    header                         = '0;
    header[XW-1:0]                 = dest_x_q;
    header[XW +: YW]               = dest_y_q;
    header[XW+YW +: XW]            = XW'(ROUTER_X);
    header[2*XW+YW +: YW]          = YW'(ROUTER_Y);
    header[2*(XW+YW) +: LW]        = len_q;
    header[DATA_WIDTH-1]           = cont_q;
  end

  // Outputs decode straight from state so data is zero whenever no flit is offered.
  always_comb begin
    state_d   = state_q;
    m_tdata_o = '0;
    m_tlast_o = 1'b0;
    case (state_q)
      COLLECT: if (s_hs && close_beat) state_d = HEADER;
      HEADER: begin
        m_tdata_o = header;
        if (m_hs) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        m_tdata_o = buffer_q[rd_q[IW-1:0]];
        m_tlast_o = last_flit;
        if (m_hs && last_flit) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= COLLECT;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      cnt_q      <= '0;
      rd_q       <= '0;
      len_q      <= '0;
      cont_q     <= 1'b0;
      first_q    <= 1'b1;
      dest_x_q   <= '0;
      dest_y_q   <= '0;
    end else begin
      state_q    <= state_d;
      s_tready_q <= (state_d == COLLECT);
      m_tvalid_q <= (state_d != COLLECT);
      case (state_q)
        COLLECT: if (s_hs) begin
          cnt_q <= cnt_inc;
          if (first_q) begin
            dest_x_q <= dest_x_i;
            dest_y_q <= dest_y_i;
            first_q  <= 1'b0;
          end
          // Only a real end of message re-arms the destination latch; fragments reuse it.
          if (close_beat) begin
            len_q   <= cnt_inc;
            cont_q  <= ~s_tlast_i;
            first_q <= s_tlast_i;
          end
        end
        HEADER: if (m_hs) rd_q <= '0;
        PAYLOAD: if (m_hs) begin
          rd_q <= rd_q + LW'(1);
          if (last_flit) cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (s_hs) buffer_q[cnt_q[IW-1:0]] <= s_tdata_i;
  end
endmodule

// File: tb/tb_noc_packetizer.sv
// tb/tb_noc_packetizer.sv - self-checking bench for noc_packetizer (vector table, directed sequences, random vs model)
module tb_noc_packetizer;
  localparam int MP = 4, XW = 2, YW = 2, RX = 0, RY = 0;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] s_tdata = '0, m_tdata;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [1:0]  dest_x = '0, dest_y = '0;
  logic        m_tvalid, m_tlast, m_tready = 1'b1;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, acc_cyc = 0, stall_seen = 0, stall_viol = 0;
  logic        tbl_mode = 1'b0, tbl_ready = 1'b1, bp_mode = 1'b0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out = '0;
  logic [32:0] got[$], exp_q[$];
  int          got_cyc[$];
  logic [31:0] msg[$];

  always #5 clk = ~clk;

  noc_packetizer dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready),
    .dest_x_i(dest_x), .dest_y_i(dest_y),
    .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast), .m_tready_i(m_tready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    m_tready <= tbl_mode ? tbl_ready : (bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  // Collects accepted flits and watches that a stalled flit stays put.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      got.push_back({m_tlast, m_tdata});
      got_cyc.push_back(cyc);
    end
    if (rst_n && prev_stall) begin
      stall_seen <= stall_seen + 1;
      if ({m_tvalid, m_tlast, m_tdata} !== prev_out) stall_viol <= stall_viol + 1;
    end
    prev_stall <= rst_n && (m_tvalid === 1'b1) && (m_tready === 1'b0);
    prev_out   <= {m_tvalid, m_tlast, m_tdata};
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] hdr(int dx, int dy, int len, bit cont);
    logic [31:0] h;
    h = 32'(dx) + (32'(dy) << XW) + (32'(RX) << (XW + YW)) + (32'(RY) << (2 * XW + YW))
        + (32'(len) << (2 * (XW + YW)));
    if (cont) h = h + 32'h8000_0000;
    return h;
  endfunction

  task automatic put_beat(logic [31:0] d, logic l, logic [1:0] x, logic [1:0] y);
    int t = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l; dest_x = x; dest_y = y;
    @(negedge clk);
    while (s_tready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 200) begin
      n_bad++;
      $display("FAIL beat_accept: s_tready got 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  // Reference: split the message into MP-beat packets, each preceded by its header.
  task automatic send_msg(logic [1:0] dx, logic [1:0] dy, int max_gap, bit scramble);
    int n = msg.size();
    for (int off = 0; off < n; off += MP) begin
      int len = (n - off < MP) ? n - off : MP;
      exp_q.push_back({1'b0, hdr(int'(dx), int'(dy), len, (off + len) < n)});
      for (int k = 0; k < len; k++) exp_q.push_back({k == len - 1, msg[off + k]});
    end
    for (int i = 0; i < n; i++) begin
      logic [1:0] bx = (i == 0 || !scramble) ? dx : 2'($urandom);
      logic [1:0] by = (i == 0 || !scramble) ? dy : 2'($urandom);
      put_beat(msg[i], i == n - 1, bx, by);
      if (max_gap > 0 && i < n - 1) repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((got.size() < exp_q.size() || s_tready !== 1'b1 || m_tvalid !== 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic score(string name);
    check({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(name, 64'(got[i]), 64'(exp_q[i]));
    got.delete(); got_cyc.delete(); exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic sv; logic [31:0] sd; logic sl; logic [1:0] dx, dy; logic mr;
    logic e_sr, e_mv, e_ml; logic [31:0] e_md;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b1, 32'hA5A5A5A5, 1'b1, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'hA5A5A5A5, 1'b1, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h106};
    tbl[3]  = '{1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h106};
    tbl[4]  = '{1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5};
    tbl[5]  = '{1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 32'h11, 1'b0, 2'd1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h0, 1'b0, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 32'h22, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20D};
    tbl[10] = '{1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11};
    tbl[11] = '{1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22};
    tbl[12] = '{1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

    // Reset values while held in reset.
    tbl_mode = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {s_tready, m_tvalid, m_tlast, m_tdata}, 35'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Cycle-accurate vectors: single-beat message with header stall, then a 2-beat message with a source gap.
    for (int i = 0; i < 13; i++) begin
      s_tvalid = tbl[i].sv; s_tdata = tbl[i].sd; s_tlast = tbl[i].sl;
      dest_x = tbl[i].dx; dest_y = tbl[i].dy; tbl_ready = tbl[i].mr;
      @(negedge clk);
      check($sformatf("vec%0d", i), {s_tready, m_tvalid, m_tlast, m_tdata},
            {tbl[i].e_sr, tbl[i].e_mv, tbl[i].e_ml, tbl[i].e_md});
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    tbl_mode = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    got.delete(); got_cyc.delete();

    // Full packet followed immediately by the next message: back-to-back flits and minimum input gap.
    begin
      int t0;
      msg = '{32'd1, 32'd2, 32'd3, 32'd4};
      send_msg(2'd1, 2'd2, 0, 1'b0);
      t0 = acc_cyc;
      msg = '{32'h55};
      send_msg(2'd3, 2'd1, 0, 1'b0);
      check("next_msg_gap", 64'(acc_cyc - t0), 64'd6);
      wait_drain();
      if (got.size() >= 5) begin
        check("full_hdr", 64'(got[0]), 64'h409);
        check("full_flit_span", 64'(got_cyc[4] - got_cyc[0]), 64'd4);
      end else check("full_flit_count", 64'(got.size()), 64'd7);
      score("full_pkt");
    end

    // Fragmentation: 6 beats become 4+2, destination changes after the first beat are ignored.
    msg = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
    send_msg(2'd3, 2'd3, 0, 1'b1);
    wait_drain();
    if (got.size() >= 6) begin
      check("frag1_hdr", 64'(got[0]), 64'h8000040F);
      check("frag2_hdr", 64'(got[5]), 64'h20F);
    end else check("frag_count", 64'(got.size()), 64'd8);
    score("frag");

    // Backpressure on a 3-beat packet.
    bp_mode = 1'b1;
    msg = '{32'hD0, 32'hD1, 32'hD2};
    send_msg(2'd1, 2'd0, 0, 1'b0);
    wait_drain();
    score("backpressure");
    bp_mode = 1'b0;

    // Source stall: gaps between beats must not count as beats.
    msg = '{32'hE0, 32'hE1, 32'hE2};
    send_msg(2'd2, 2'd2, 3, 1'b0);
    wait_drain();
    if (got.size() >= 1) check("stall_len_hdr", 64'(got[0]), 64'h30A);
    score("src_stall");

    // Reset during PAYLOAD once header and first data flit are out.
    begin
      int t = 0;
      put_beat(32'd21, 1'b0, 2'd1, 2'd1);
      put_beat(32'd22, 1'b0, 2'd1, 2'd1);
      put_beat(32'd23, 1'b1, 2'd1, 2'd1);
      @(negedge clk);
      while (!(m_tvalid === 1'b1 && m_tready === 1'b1 && m_tdata === 32'd21) && t < 50) begin
        @(negedge clk);
        t++;
      end
      @(posedge clk);
      #1;
      check("pre_reset_flit", {m_tvalid, m_tdata}, {1'b1, 32'd22});
      rst_n = 1'b0;
      #1;
      check("mid_reset_outputs", {s_tready, m_tvalid, m_tlast, m_tdata}, 35'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete(); got_cyc.delete(); exp_q.delete();
      @(negedge clk);
      check("post_reset_tready0", 64'(s_tready), 64'd0);
      @(posedge clk);
      #1;
      check("post_reset_tready1", 64'(s_tready), 64'd1);
      msg = '{32'hCAFEF00D};
      send_msg(2'd3, 2'd0, 0, 1'b0);
      wait_drain();
      if (got.size() >= 1) check("post_reset_hdr", 64'(got[0]), 64'h103);
      score("post_reset");
    end

    // Randomized messages with backpressure, source gaps and destination churn.
    bp_mode = 1'b1;
    for (int m = 0; m < 25; m++) begin
      int n = $urandom_range(1, 10);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back($urandom);
      send_msg(2'($urandom), 2'($urandom), 2, 1'b1);
    end
    wait_drain();
    score("random");
    bp_mode = 1'b0;

    check("stall_hold_violations", 64'(stall_viol), 64'd0);
    check("stall_observed", 64'(stall_seen > 0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
